// File: rtl/mem_checker_pkg.sv
// Shared types and helpers for the memory checker datapath.
// Holds the command opcode, the burst master FSM states and the burst clamp limit.
package mem_checker_pkg;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Largest burst a BURST_W-bit burstcount may legally carry.
  function automatic int max_burst(input int burst_w);
    return 1 << (burst_w - 1);
  endfunction

endpackage

// File: rtl/amm_pattern_gen.sv
// Incrementing data pattern source: word for beat i is seed + i (mod 2**DATA_W).
// One instance feeds both the write data path and the read compare path.
module amm_pattern_gen #(
  parameter int DATA_W  = 64,
  parameter int BURST_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DATA_W-1:0]  seed,
  input  logic               advance,
  output logic [BURST_W-1:0] beat,
  output logic [DATA_W-1:0]  data
);

  logic [DATA_W-1:0]  seed_q, seed_d;
  logic [BURST_W-1:0] beat_q, beat_d;

  always_comb begin
    seed_d = seed_q;
    beat_d = beat_q;
    if (load) begin
      seed_d = seed;
      beat_d = '0;
    end else if (advance) begin
      beat_d = beat_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= '0;
      beat_q <= '0;
    end else begin
      seed_q <= seed_d;
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;
  assign data = seed_q + DATA_W'(beat_q);

endmodule

// File: rtl/amm_burst_master.sv
// Avalon-MM burst master: runs one write-pattern or read-and-check burst per command.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE.
module amm_burst_master
  import mem_checker_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_W   = 11,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [BURST_W-1:0]   cmd_burst,
  input  logic [DATA_W-1:0]    cmd_seed,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [BURST_W-1:0]   err_beat,
  output logic [ADDR_W-1:0]    amm_address,
  output logic                 amm_read,
  output logic                 amm_write,
  output logic [DATA_W-1:0]    amm_writedata,
  output logic [DATA_W/8-1:0]  amm_byteenable,
  output logic [BURST_W-1:0]   amm_burstcount,
  input  logic                 amm_readdatavalid,
  input  logic [DATA_W-1:0]    amm_readdata,
  input  logic                 amm_waitrequest
);

  localparam logic [BURST_W-1:0] MAX_BURST = BURST_W'(max_burst(BURST_W));

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   done_q, done_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [BURST_W-1:0]     err_beat_q, err_beat_d;
  logic [ADDR_W-1:0]      amm_address_q, amm_address_d;
  logic                   amm_read_q, amm_read_d;
  logic                   amm_write_q, amm_write_d;
  logic [BURST_W-1:0]     amm_burstcount_q, amm_burstcount_d;

  logic [BURST_W-1:0]     cmd_len;
  logic                   pat_load;
  logic                   pat_adv;
  logic [BURST_W-1:0]     pat_beat;
  logic [DATA_W-1:0]      pat_data;
  logic                   last_beat;

  assign cmd_len   = (cmd_burst > MAX_BURST) ? MAX_BURST : cmd_burst;
  // burstcount doubles as the latched burst length for the whole command.
  assign last_beat = (pat_beat == amm_burstcount_q - BURST_W'(1));

  amm_pattern_gen #(
    .DATA_W  (DATA_W),
    .BURST_W (BURST_W)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (pat_load),
    .seed    (cmd_seed),
    .advance (pat_adv),
    .beat    (pat_beat),
    .data    (pat_data)
  );

  always_comb begin
    state_d          = state_q;
    cmd_ready_d      = cmd_ready_q;
    done_d           = 1'b0;
    err_cnt_d        = err_cnt_q;
    err_beat_d       = err_beat_q;
    amm_address_d    = amm_address_q;
    amm_read_d       = amm_read_q;
    amm_write_d      = amm_write_q;
    amm_burstcount_d = amm_burstcount_q;
    pat_load         = 1'b0;
    pat_adv          = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d      = 1'b0;
          pat_load         = 1'b1;
          amm_address_d    = cmd_addr;
          amm_burstcount_d = cmd_len;
          err_cnt_d        = '0;
          err_beat_d       = '0;
          if (cmd_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (op_t'(cmd_op) == OP_READ) begin
            state_d    = RD_REQ;
            amm_read_d = 1'b1;
          end else begin
            state_d     = WR;
            amm_write_d = 1'b1;
          end
        end
      end
      WR: begin
        if (!amm_waitrequest) begin
          pat_adv = 1'b1;
          if (last_beat) begin
            amm_write_d = 1'b0;
            state_d     = DONE;
            done_d      = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (!amm_waitrequest) begin
          amm_read_d = 1'b0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (amm_readdatavalid) begin
          pat_adv = 1'b1;
          if (amm_readdata != pat_data) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (err_cnt_q == '0) err_beat_d = pat_beat;
          end
          if (last_beat) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cmd_ready_q      <= 1'b1;
      done_q           <= 1'b0;
      err_cnt_q        <= '0;
      err_beat_q       <= '0;
      amm_address_q    <= '0;
      amm_read_q       <= 1'b0;
      amm_write_q      <= 1'b0;
      amm_burstcount_q <= '0;
    end else begin
      state_q          <= state_d;
      cmd_ready_q      <= cmd_ready_d;
      done_q           <= done_d;
      err_cnt_q        <= err_cnt_d;
      err_beat_q       <= err_beat_d;
      amm_address_q    <= amm_address_d;
      amm_read_q       <= amm_read_d;
      amm_write_q      <= amm_write_d;
      amm_burstcount_q <= amm_burstcount_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign done           = done_q;
  assign err_cnt        = err_cnt_q;
  assign err_beat       = err_beat_q;
  assign amm_address    = amm_address_q;
  assign amm_read       = amm_read_q;
  assign amm_write      = amm_write_q;
  assign amm_burstcount = amm_burstcount_q;
  assign amm_writedata  = pat_data;
  assign amm_byteenable = '1;

endmodule
